gpio_irq: RTL and testbench
===========================

// Module: gpio_irq
// PURPOSE
//  Parametrised GPIO peripheral on the core's simple register bus (we_i/addr_i/data_i/data_o).
//  Per-pin direction and output data. Multi-stage input synchroniser. Per-pin rising/falling
//  edge detection, with sticky pending bits and a single level interrupt to the interrupt
//  controller. Sits beside uart/timer in the peripheral address map; pads live outside.
// PARAMETERS
//  NUM_PINS     16   number of GPIO pins, legal 1..32
//  SYNC_STAGES  2    input synchroniser depth, legal >=2
// PORTS
//  clk_i      in   1         single clock, all state on posedge
//  rst_i      in   1         synchronous, active-high reset
//  we_i       in   1         register write strobe, one write per cycle
//  addr_i     in   32        byte address; only addr_i[4:0] decoded, upper bits ignored
//  data_i     in   32        write data
//  data_o     out  32        read data, combinational from addr_i
//  gpio_i     in   NUM_PINS  asynchronous pad inputs
//  gpio_o     out  NUM_PINS  pad output data (= OUT register)
//  gpio_oe_o  out  NUM_PINS  pad output enable (= DIR register, 1 = drive)
//  irq_o      out  1         |(IP & IE), combinational from registers
// BEHAVIOUR
//  Register map (offset, access):
//   0x00 DIR RW | 0x04 OUT RW | 0x08 IN RO | 0x0C IE RW | 0x10 IP RW1C | 0x14 RISE_EN RW | 0x18 FALL_EN RW
//  - Bits [31:NUM_PINS] of every register: read 0, writes ignored.
//  - Unmapped offsets: read 0, writes ignored. Writes to IN are ignored.
//  - Reset: every register = 0, synchroniser stages = 0, prev = 0.
//    Outputs after reset: gpio_o = 0, gpio_oe_o = 0 (all pins hi-Z), irq_o = 0.
//    data_o = 0 while rst_i = 1.
//  - Write: the register updates at the posedge where we_i = 1; the new value is readable the next cycle.
//  - Synchroniser: gpio_i passes through SYNC_STAGES flops; the last stage is `sync`.
//    - IN reads `sync`.
//    - A pin change sampled at edge k is visible in IN after edge k+SYNC_STAGES-1.
//  - Edge detect:
//    - prev <= sync every cycle.
//    - rise = sync & ~prev; fall = ~sync & prev.
//    - Detection covers all pins regardless of DIR, so an output pin looped back at the pad is seen.
//  - Pending update, per bit, each cycle:
//      IP_next = (IP & ~(we_i && addr==0x10 ? data_i : 0)) | (rise & RISE_EN) | (fall & FALL_EN)
//    - A new event in the same cycle as a W1C of that bit wins: the bit stays 1.
//    - IP bits set independently of IE. IE only gates irq_o.
//    - Enabling IE with IP already set asserts irq_o the cycle after the write.
//  - Latency: pin toggle sampled at edge k -> IP set, and irq_o high if enabled, after edge k+SYNC_STAGES.
//  - Spurious events at reset are harmless: prev = 0 means a high pin produces `rise` once the
//    chain fills, but RISE_EN = 0 at reset, so IP is not set.
//  - Reset mid-operation: all state clears on the reset edge; pending events are lost; irq_o drops
//    the cycle rst_i is sampled.
//  - Writing DIR/OUT takes effect on gpio_oe_o/gpio_o the cycle after the write; no glitch
//    ordering between the two is guaranteed.
// STRUCTURE
//  - gpio_pkg:
//    - localparams for the register offsets (GPIO_DIR .. GPIO_FALL_EN)
//    - typedef gpio_reg_e (enum over addr[4:0])
//    - GPIO_MAX_PINS = 32
//  - Sub-module gpio_sync #(WIDTH, STAGES): the synchroniser chain, reset to 0.
//    Instantiated once, WIDTH = NUM_PINS.
//  - Top holds the register file, edge detect, the IP update and the read mux.
// TESTING
//  1. Reset with gpio_i = 'hFFFF -> all reads 0 except IN = 0xFFFF after SYNC_STAGES cycles;
//     irq_o = 0; IP = 0.
//  2. Write DIR = 0x00FF, OUT = 0x00A5; also write 0xFFFFFFFF to DIR
//     -> gpio_oe_o = 0x00FF, gpio_o = 0x00A5; DIR then reads 0x0000FFFF (upper bits masked).
//  3. RISE_EN = 0x1, IE = 0x1; drive gpio_i[0] 0->1 at edge k
//     -> IP = 0x1 and irq_o = 1 after edge k+2; write IP = 0x1 -> irq_o = 0 next cycle.
//  4. FALL_EN = 0x4, IE = 0; drop gpio_i[2] -> IP = 0x4, irq_o = 0; write IE = 0x4 -> irq_o = 1 next cycle.
//  5. Same-cycle W1C of IP[0] and a new rise event on pin 0 -> IP[0] stays 1.
//     W1C of 0x2 while IP = 0x3 -> IP = 0x1.
//  6. Assert rst_i with IP = 0xF and irq_o = 1 -> next cycle all registers 0, irq_o = 0;
//     read offset 0x1C -> data_o = 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants and register-select type for the GPIO interrupt peripheral.
package gpio_pkg;

    localparam int unsigned GPIO_MAX_PINS = 32;
    localparam int unsigned GPIO_ADDR_W   = 5;
    localparam int unsigned GPIO_DATA_W   = 32;

    // Register byte offsets within the peripheral window
    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR     = 5'h00;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT     = 5'h04;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IN      = 5'h08;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IE      = 5'h0C;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IP      = 5'h10;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE_EN = 5'h14;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL_EN = 5'h18;

    typedef enum logic [GPIO_ADDR_W-1:0] {
        REG_DIR     = GPIO_DIR,
        REG_OUT     = GPIO_OUT,
        REG_IN      = GPIO_IN,
        REG_IE      = GPIO_IE,
        REG_IP      = GPIO_IP,
        REG_RISE_EN = GPIO_RISE_EN,
        REG_FALL_EN = GPIO_FALL_EN
    } gpio_reg_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; every stage clears on reset.
module gpio_sync #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the pad value through the chain one stage per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral: direction/output registers, synchronised inputs, edge-triggered
// sticky pending bits and a single level interrupt.
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_PINS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oe_o,
    output logic                irq_o
);

    localparam int unsigned W = NUM_PINS;

    logic [W-1:0] dir_q;
    logic [W-1:0] out_q;
    logic [W-1:0] ie_q;
    logic [W-1:0] ip_q;
    logic [W-1:0] rise_en_q;
    logic [W-1:0] fall_en_q;
    logic [W-1:0] prev_q;

    logic [W-1:0] sync;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] wdata;
    logic [W-1:0] w1c_mask;
    logic [W-1:0] ip_next;
    logic [31:0]  rdata;
    gpio_reg_e    reg_sel;

    // Bus bits that carry no meaning for this block
    logic unused_bus;
    assign unused_bus = ^{addr_i[31:GPIO_ADDR_W], data_i};

    gpio_sync #(
        .WIDTH  (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (gpio_i),
        .q_o   (sync)
    );

    assign reg_sel = gpio_reg_e'(addr_i[GPIO_ADDR_W-1:0]);
    assign wdata   = data_i[W-1:0];

    // Edge detect and pending update; a fresh event beats a same-cycle clear
    always_comb begin
        rise     = sync & ~prev_q;
        fall     = ~sync & prev_q;
        w1c_mask = (we_i && reg_sel == REG_IP) ? wdata : '0;
        ip_next  = (ip_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Register file, previous-sample flop and pending bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q     <= '0;
            out_q     <= '0;
            ie_q      <= '0;
            ip_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            prev_q    <= '0;
        end else begin
            prev_q <= sync;
            ip_q   <= ip_next;
            if (we_i) begin
                case (reg_sel)
                    REG_DIR:     dir_q     <= wdata;
                    REG_OUT:     out_q     <= wdata;
                    REG_IE:      ie_q      <= wdata;
                    REG_RISE_EN: rise_en_q <= wdata;
                    REG_FALL_EN: fall_en_q <= wdata;
                    default:     ;
                endcase
            end
        end
    end

    // Read mux, zero-extended, forced to zero while in reset
    always_comb begin
        rdata = '0;
        if (!rst_i) begin
            case (reg_sel)
                REG_DIR:     rdata = 32'(dir_q);
                REG_OUT:     rdata = 32'(out_q);
                REG_IN:      rdata = 32'(sync);
                REG_IE:      rdata = 32'(ie_q);
                REG_IP:      rdata = 32'(ip_q);
                REG_RISE_EN: rdata = 32'(rise_en_q);
                REG_FALL_EN: rdata = 32'(fall_en_q);
                default:     rdata = '0;
            endcase
        end
    end

    assign data_o    = rdata;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = |(ip_q & ie_q);

endmodule

// File: tb/tb_gpio_irq.sv
// Directed plus randomized bench for gpio_irq against a delay-line reference model.
module tb_gpio_irq;

    localparam int unsigned NP = 16;
    localparam int unsigned S  = 2;
    localparam logic [31:0] MASK = 32'h0000FFFF;

    logic          clk_i;
    logic          rst_i;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic [31:0]   data_o;
    logic [NP-1:0] gpio_i;
    logic [NP-1:0] gpio_o;
    logic [NP-1:0] gpio_oe_o;
    logic          irq_o;

    int errors = 0;
    int checks = 0;

    // Reference model state: registers plus a history of pad samples, newest first
    logic [31:0] m_dir, m_out, m_ie, m_ip, m_rise, m_fall;
    logic [31:0] hist[$];

    gpio_irq #(
        .NUM_PINS    (NP),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pad sample taken i edges ago (0 before the chain has filled)
    function automatic logic [31:0] hget(input int i);
        return (i < hist.size()) ? hist[i] : 32'h0;
    endfunction

    // One clock edge of the reference model
    task automatic mstep(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] pins);
        logic [31:0] sync, prev, rise, fall, clr, ipn;
        if (r) begin
            m_dir = 0; m_out = 0; m_ie = 0; m_ip = 0; m_rise = 0; m_fall = 0;
            hist.delete();
            return;
        end
        sync = hget(S - 1);
        prev = hget(S);
        rise = sync & ~prev;
        fall = ~sync & prev;
        clr  = (w && a[4:0] == 5'h10) ? (d & MASK) : 32'h0;
        ipn  = (m_ip & ~clr) | (rise & m_rise) | (fall & m_fall);
        if (w) begin
            case (a[4:0])
                5'h00: m_dir  = d & MASK;
                5'h04: m_out  = d & MASK;
                5'h0C: m_ie   = d & MASK;
                5'h14: m_rise = d & MASK;
                5'h18: m_fall = d & MASK;
                default: ;
            endcase
        end
        m_ip = ipn;
        hist.push_front(pins & MASK);
        if (hist.size() > S + 1) void'(hist.pop_back());
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a, input logic r);
        if (r) return 32'h0;
        case (a[4:0])
            5'h00:   return m_dir;
            5'h04:   return m_out;
            5'h08:   return hget(S - 1);
            5'h0C:   return m_ie;
            5'h10:   return m_ip;
            5'h14:   return m_rise;
            5'h18:   return m_fall;
            default: return 32'h0;
        endcase
    endfunction

    // Drive one bus cycle, advance model and DUT, then compare all outputs
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rst_i  = r;
        we_i   = w;
        addr_i = a;
        data_i = d;
        mstep(r, w, a, d, 32'(gpio_i));
        @(posedge clk_i);
        #1;
        chk("data_o", data_o, mread(a, r));
        chk("gpio_o", 32'(gpio_o), m_out);
        chk("gpio_oe_o", 32'(gpio_oe_o), m_dir);
        chk("irq_o", 32'(irq_o), 32'(|(m_ip & m_ie)));
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    logic [4:0] offs [8];

    initial begin
        offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
        rst_i = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0;
        gpio_i = 16'hFFFF;

        // Reset with all pads high; IN fills after the synchroniser depth
        cycle(1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 32'h8, 32'h0);
        chk("rst_data_o", data_o, 32'h0);
        rd(32'h8);
        chk("in_filling", data_o, 32'h0);
        rd(32'h8);
        chk("in_filled", data_o, 32'h0000FFFF);
        rd(32'h10);
        chk("rst_ip", data_o, 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);

        // Direction and output data, upper bits masked
        wr(32'h0, 32'h00FF);
        wr(32'h4, 32'h00A5);
        chk("oe_dir", 32'(gpio_oe_o), 32'h00FF);
        chk("out_data", 32'(gpio_o), 32'h00A5);
        wr(32'h0, 32'hFFFFFFFF);
        rd(32'h0);
        chk("dir_masked", data_o, 32'h0000FFFF);

        // Rising edge on pin 0 with interrupt enabled, then W1C
        gpio_i = 16'h0000;
        rd(32'h8); rd(32'h8); rd(32'h8);
        wr(32'h14, 32'h1);
        wr(32'h0C, 32'h1);
        gpio_i[0] = 1'b1;
        rd(32'h10);
        rd(32'h10);
        chk("rise_k1_ip", data_o, 32'h0);
        rd(32'h10);
        chk("rise_ip", data_o, 32'h1);
        chk("rise_irq", 32'(irq_o), 32'h1);
        wr(32'h10, 32'h1);
        chk("w1c_irq", 32'(irq_o), 32'h0);

        // Falling edge on pin 2 while masked, then enable
        gpio_i[2] = 1'b1;
        rd(32'h8); rd(32'h8); rd(32'h8);
        wr(32'h18, 32'h4);
        wr(32'h0C, 32'h0);
        gpio_i[2] = 1'b0;
        rd(32'h10); rd(32'h10); rd(32'h10);
        chk("fall_ip", data_o, 32'h4);
        chk("fall_irq_masked", 32'(irq_o), 32'h0);
        wr(32'h0C, 32'h4);
        chk("ie_late_irq", 32'(irq_o), 32'h1);

        // New event beats a same-cycle clear; partial W1C
        wr(32'h10, 32'hFFFF);
        gpio_i[0] = 1'b0;
        rd(32'h10); rd(32'h10); rd(32'h10);
        gpio_i[0] = 1'b1;
        rd(32'h10); rd(32'h10); rd(32'h10);
        gpio_i[0] = 1'b0;
        rd(32'h10); rd(32'h10); rd(32'h10);
        gpio_i[0] = 1'b1;
        rd(32'h10); rd(32'h10);
        wr(32'h10, 32'h1);
        chk("w1c_race", data_o, 32'h1);
        wr(32'h14, 32'h3);
        gpio_i[1] = 1'b1;
        rd(32'h10); rd(32'h10); rd(32'h10);
        chk("ip_two", data_o, 32'h3);
        wr(32'h10, 32'h2);
        chk("w1c_partial", data_o, 32'h1);

        // Reset mid-operation with interrupt pending
        wr(32'h10, 32'hFFFF);
        gpio_i = 16'h0000;
        rd(32'h8); rd(32'h8); rd(32'h8);
        wr(32'h14, 32'hF);
        wr(32'h0C, 32'hF);
        gpio_i = 16'h000F;
        rd(32'h10); rd(32'h10); rd(32'h10);
        chk("pre_rst_ip", data_o, 32'hF);
        chk("pre_rst_irq", 32'(irq_o), 32'h1);
        cycle(1'b1, 1'b0, 32'h10, 32'h0);
        chk("mid_rst_irq", 32'(irq_o), 32'h0);
        chk("mid_rst_oe", 32'(gpio_oe_o), 32'h0);
        rd(32'h1C);
        chk("unmapped", data_o, 32'h0);
        rd(32'h10);
        chk("post_rst_ip", data_o, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        r;
            logic        w;
            a = {27'($urandom), offs[$urandom_range(0, 7)]};
            if ($urandom_range(0, 7) == 0) a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) d = d & 32'h0000FFFF;
            r = ($urandom_range(0, 79) == 0);
            w = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       gpio_i = 16'($urandom);
                1:       gpio_i[$urandom_range(0, NP - 1)] = ~gpio_i[$urandom_range(0, NP - 1)];
                default: ;
            endcase
            cycle(r, w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
